// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable symbol-sequence detector.
package seq_det_pkg;

    localparam int DEF_SYM_W   = 2;
    localparam int DEF_SEQ_LEN = 3;
    localparam int DEF_PROG_W  = $clog2(DEF_SEQ_LEN);
    // Upper bounds accepted by pat_elem
    localparam int SYM_MAX     = 8;
    localparam int PAT_MAX     = 64;

    typedef logic [DEF_SYM_W-1:0]  sym_t;
    typedef logic [DEF_PROG_W-1:0] prog_t;

    // Element i of a packed pattern of w-bit symbols, element 0 in the LSBs.
    function automatic logic [SYM_MAX-1:0] pat_elem(input logic [PAT_MAX-1:0] pv,
                                                    input int i, input int w);
        logic [SYM_MAX-1:0] r;
        r = SYM_MAX'(pv >> (i * w));
        for (int b = 0; b < SYM_MAX; b++)
            if (b >= w) r[b] = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/seq_detector_prog_fallback.sv
// Next-progress computation: advance on a hit, otherwise fall back to the
// longest pattern prefix that is a suffix of what has been seen.
module seq_fallback
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    localparam int PW     = $clog2(SEQ_LEN)
) (
    input  logic [SEQ_LEN*SYM_W-1:0] i_pattern,
    input  logic [PW-1:0]            i_p,
    input  logic [SYM_W-1:0]         i_x,
    input  logic                     i_mode_overlap,
    output logic [PW-1:0]            o_next,
    output logic                     o_match
);

    logic [SYM_W-1:0] w_pat [SEQ_LEN];

    for (genvar n = 0; n < SEQ_LEN; n++) begin : g_unpack
        assign w_pat[n] = SYM_W'(pat_elem(PAT_MAX'(i_pattern), n, SYM_W));
    end

    int               w_pi, w_idx, w_best;
    logic             w_ok, w_hit;
    logic [SYM_W-1:0] w_cur;

    always_comb begin
        w_pi   = int'(i_p);
        w_idx  = 0;
        w_best = 0;
        w_ok   = 1'b0;
        w_cur  = '0;
        for (int n = 0; n < SEQ_LEN; n++)
            if (n == w_pi) w_cur = w_pat[n];
        // k-long candidate: pat[p-k+1 .. p-1] ++ x must equal pat[0 .. k-1]
        for (int k = 1; k < SEQ_LEN; k++) begin
            w_ok = (k <= w_pi) && (i_x == w_pat[k-1]);
            for (int j = 0; j < SEQ_LEN; j++) begin
                if (j < k - 1) begin
                    w_idx = w_pi - k + 1 + j;
                    for (int n = 0; n < SEQ_LEN; n++)
                        if (n == w_idx && w_pat[n] != w_pat[j]) w_ok = 1'b0;
                end
            end
            if (w_ok) w_best = k;
        end
        w_hit   = (i_x == w_cur);
        o_match = w_hit && (w_pi == SEQ_LEN - 1);
        if (w_hit && !o_match)  o_next = PW'(w_pi + 1);
        else if (i_mode_overlap) o_next = PW'(w_best);
        else if (o_match)        o_next = '0;
        else                     o_next = (i_x == w_pat[0]) ? PW'(1) : '0;
    end

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable sequence detector: pattern, progress, alarm and
// saturating match counter registers around the combinational fallback.
module seq_detector_prog
    import seq_det_pkg::*;
#(
    parameter int SYM_W   = DEF_SYM_W,
    parameter int SEQ_LEN = DEF_SEQ_LEN,
    parameter int CNT_W   = 8,
    parameter logic [SEQ_LEN*SYM_W-1:0] RST_PATTERN = {2'b11, 2'b10, 2'b01}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       cfg_load,
    input  logic [SEQ_LEN*SYM_W-1:0]   cfg_pattern,
    input  logic                       mode_overlap,
    input  logic                       mode_latch,
    input  logic                       alarm_clr,
    input  logic                       sym_valid,
    input  logic [SYM_W-1:0]           sym,
    output logic                       match_pulse,
    output logic                       alarm,
    output logic [$clog2(SEQ_LEN)-1:0] progress,
    output logic [CNT_W-1:0]           match_count
);

    localparam int PW = $clog2(SEQ_LEN);

    logic [SEQ_LEN*SYM_W-1:0] r_pattern;
    logic [PW-1:0]            r_progress;
    logic                     r_match_pulse, r_alarm;
    logic [CNT_W-1:0]         r_count;

    logic [PW-1:0] w_next;
    logic          w_match, w_fire;

    seq_fallback #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN)) u_fallback (
        .i_pattern      (r_pattern),
        .i_p            (r_progress),
        .i_x            (sym),
        .i_mode_overlap (mode_overlap),
        .o_next         (w_next),
        .o_match        (w_match)
    );

    assign w_fire = sym_valid && !cfg_load && w_match;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pattern     <= RST_PATTERN;
            r_progress    <= '0;
            r_match_pulse <= 1'b0;
            r_alarm       <= 1'b0;
            r_count       <= '0;
        end else begin
            r_match_pulse <= w_fire;
            if (cfg_load) begin
                r_pattern  <= cfg_pattern;
                r_progress <= '0;
            end else if (sym_valid) begin
                r_progress <= w_next;
            end
            if (w_fire && r_count != {CNT_W{1'b1}})
                r_count <= r_count + 1'b1;
            // Set beats clear; leaving latch mode drops a held alarm.
            if (!mode_latch)   r_alarm <= w_fire;
            else if (w_fire)   r_alarm <= 1'b1;
            else if (alarm_clr) r_alarm <= 1'b0;
        end
    end

    assign match_pulse = r_match_pulse;
    assign alarm       = r_alarm;
    assign progress    = r_progress;
    assign match_count = r_count;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Scoreboard bench for seq_detector_prog: a behavioural model predicts each
// cycle's outputs; a second instance with a 2-bit counter checks saturation.
module tb_seq_detector_prog;
    import seq_det_pkg::*;

    localparam int L = 3;
    localparam int W = 2;

    logic           clk = 1'b0;
    logic           reset, cfg_load, mode_overlap, mode_latch, alarm_clr, sym_valid;
    logic [L*W-1:0] cfg_pattern;
    sym_t           sym;
    logic           match_pulse, alarm, mp2, al2;
    logic [1:0]     progress, pr2;
    logic [7:0]     match_count;
    logic [1:0]     mc2;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .mode_overlap(mode_overlap), .mode_latch(mode_latch), .alarm_clr(alarm_clr),
        .sym_valid(sym_valid), .sym(sym), .match_pulse(match_pulse), .alarm(alarm),
        .progress(progress), .match_count(match_count)
    );

    seq_detector_prog #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .mode_overlap(mode_overlap), .mode_latch(mode_latch), .alarm_clr(alarm_clr),
        .sym_valid(sym_valid), .sym(sym), .match_pulse(mp2), .alarm(al2),
        .progress(pr2), .match_count(mc2)
    );

    typedef struct {
        int prog;
        bit pulse;
        bit alarm;
        int cnt;
        int cnt2;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    int   m_pat [L];
    int   m_prog, m_cnt, m_cnt2;
    bit   m_alarm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: longest suffix of (matched prefix ++ x) that is a prefix of the pattern.
    function automatic int model_next(input int p, input int x, output bit hit_full);
        int s [L];
        int len;
        bit ok;
        hit_full = 1'b0;
        for (int i = 0; i < p; i++) s[i] = m_pat[i];
        s[p] = x;
        if (x == m_pat[p]) begin
            if (p + 1 < L) return p + 1;
            hit_full = 1'b1;
            if (!mode_overlap) return 0;
            len = L;
        end else begin
            if (!mode_overlap) return (x == m_pat[0]) ? 1 : 0;
            len = p + 1;
        end
        for (int k = len - 1; k >= 1; k--) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++)
                if (s[len - k + j] != m_pat[j]) ok = 1'b0;
            if (ok) return k;
        end
        return 0;
    endfunction

    task automatic step(input string tag, input bit rst, input bit ld, input logic [L*W-1:0] pat,
                        input bit v, input int x, input bit clr);
        exp_t e;
        bit   fire;
        reset       = rst;
        cfg_load    = ld;
        cfg_pattern = pat;
        sym_valid   = v;
        sym         = W'(x);
        alarm_clr   = clr;
        fire        = 1'b0;
        if (rst) begin
            m_pat   = '{1, 2, 3};
            m_prog  = 0;
            m_alarm = 1'b0;
            m_cnt   = 0;
            m_cnt2  = 0;
        end else begin
            if (ld) begin
                for (int i = 0; i < L; i++) m_pat[i] = int'(pat[i*W +: W]);
                m_prog = 0;
            end else if (v) begin
                m_prog = model_next(m_prog, x, fire);
            end
            if (fire) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (!mode_latch) m_alarm = fire;
            else if (fire)   m_alarm = 1'b1;
            else if (clr)    m_alarm = 1'b0;
        end
        e.prog  = m_prog;
        e.pulse = fire;
        e.alarm = m_alarm;
        e.cnt   = m_cnt;
        e.cnt2  = m_cnt2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".prog"},  32'(progress),    32'(e.prog));
        chk({tag, ".pulse"}, 32'(match_pulse), 32'(e.pulse));
        chk({tag, ".alarm"}, 32'(alarm),       32'(e.alarm));
        chk({tag, ".cnt"},   32'(match_count), 32'(e.cnt));
        chk({tag, ".cnt2"},  32'(mc2),         32'(e.cnt2));
    endtask

    task automatic feed(input string tag, input int x);
        step(tag, 1'b0, 1'b0, '0, 1'b1, x, 1'b0);
    endtask

    task automatic idle(input string tag, input bit clr);
        step(tag, 1'b0, 1'b0, '0, 1'b0, 0, clr);
    endtask

    task automatic load(input string tag, input int a, input int b, input int c);
        logic [L*W-1:0] p;
        p = {W'(c), W'(b), W'(a)};
        step(tag, 1'b0, 1'b1, p, 1'b0, 0, 1'b0);
    endtask

    initial begin
        int s1 [5];
        mode_overlap = 1'b0;
        mode_latch   = 1'b0;
        step("rst", 1'b1, 1'b0, '0, 1'b0, 0, 1'b0);
        step("rst", 1'b1, 1'b0, '0, 1'b1, 1, 1'b0);

        feed("basic1", 1); feed("basic2", 2); feed("basic3", 3);

        s1 = '{1, 2, 1, 2, 3};
        foreach (s1[i]) feed("restart", s1[i]);
        foreach (s1[i]) begin
            feed("gaps", s1[i]);
            idle("gaps_idle", 1'b0);
            idle("gaps_idle", 1'b0);
        end

        load("ld111", 1, 1, 1);
        mode_overlap = 1'b1;
        repeat (5) feed("ovl111", 1);
        load("ld111b", 1, 1, 1);
        mode_overlap = 1'b0;
        repeat (5) feed("rst111", 1);

        load("ld123", 1, 2, 3);
        mode_latch = 1'b1;
        feed("latch", 1); feed("latch", 2); feed("latch", 3);
        repeat (5) idle("latch_hold", 1'b0);
        feed("latch", 1); feed("latch", 2);
        step("latch_setclr", 1'b0, 1'b0, '0, 1'b1, 3, 1'b1);
        idle("latch_clr", 1'b1);
        idle("latch_off", 1'b0);
        feed("latch", 1); feed("latch", 2); feed("latch", 3);
        mode_latch = 1'b0;
        idle("latch_drop", 1'b0);

        feed("midrst", 1); feed("midrst", 2);
        step("midrst_rst", 1'b1, 1'b0, '0, 1'b1, 3, 1'b0);
        feed("midrst_after", 3);

        for (int i = 0; i < 400; i++) begin
            bit rst, ld, v, clr;
            if ($urandom_range(0, 15) == 0) mode_overlap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) mode_latch   = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 79) == 0);
            ld  = ($urandom_range(0, 24) == 0);
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 7) == 0);
            step("rand", rst, ld, L*W'($urandom_range(0, 63)), v,
                 int'($urandom_range(0, 3)), clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
Name: seq_detector_prog

Overview:
Parametrised, runtime-programmable symbol-sequence detector for the lamp/alarm subsystem. It watches a stream of W-bit symbols qualified by a valid strobe and raises an alarm when a loaded pattern of SEQ_LEN symbols appears. Overlapping or restart matching, pulse or latched alarm, and the pattern are all selectable at runtime. A saturating match counter is kept.

Parameters:
SYM_W, 2, symbol width in bits
SEQ_LEN, 3, pattern length in symbols (>=2)
CNT_W, 8, match counter width
RST_PATTERN, {2'b11,2'b10,2'b01}, reset pattern; element 0 is in the LSBs (default sequence 1,2,3)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cfg_load  in  1  load cfg_pattern this cycle
cfg_pattern  in  SEQ_LEN*SYM_W  new pattern; element i is at bits [i*SYM_W +: SYM_W]
mode_overlap  in  1  1 = overlapping (KMP fallback); 0 = restart matching
mode_latch  in  1  1 = alarm latched until alarm_clr; 0 = alarm is a one-cycle pulse
alarm_clr  in  1  clear latched alarm
sym_valid  in  1  sym is valid this cycle
sym  in  SYM_W  input symbol
match_pulse  out  1  one-cycle pulse per detected match
alarm  out  1  alarm output
progress  out  $clog2(SEQ_LEN)  matched-prefix length (0..SEQ_LEN-1)
match_count  out  CNT_W  saturating match count

Behaviour:
- Reset (synchronous, active-high; clock clk): pattern=RST_PATTERN, progress=0, match_pulse=0, alarm=0, match_count=0. Reset overrides all other inputs.
- cfg_load=1: pattern<=cfg_pattern, progress<=0. sym is ignored that cycle. match_count and alarm are unchanged.
- sym_valid=0: no state change. match_pulse=0 on the next cycle; a latched alarm holds.
- sym_valid=1, cfg_load=0, with p=progress and x=sym:
  - x==pat[p] and p+1<SEQ_LEN: progress<=p+1.
  - x==pat[p] and p+1==SEQ_LEN: this is a match. match_pulse<=1 on the next cycle (1-cycle latency from the completing symbol).
    - Overlap mode: progress<=B, where B is the length of the longest proper border of the full pattern.
    - Restart mode: progress<=0.
  - Mismatch:
    - Overlap mode: progress<=the largest k<=p such that the last k symbols of (pat[0..p-1],x) equal pat[0..k-1]. k=0 if none.
    - Restart mode: progress<=(x==pat[0]) ? 1 : 0.
- mode_overlap and mode_latch are sampled every cycle. Changing them mid-sequence takes effect on the next valid symbol; progress is not cleared.
- alarm:
  - mode_latch=0: alarm equals match_pulse.
  - mode_latch=1: alarm sets on a match and clears on alarm_clr. If a match and alarm_clr occur in the same cycle, set wins.
  - Switching latch to pulse mode drops any latched alarm on the next cycle.
- match_count increments by 1 per match and saturates at 2^CNT_W-1. It is cleared only by reset.
- All outputs are registered; there are no combinational paths from input to output.

Decomposition:
- Package seq_det_pkg: symbol typedef sym_t (logic [SYM_W-1:0]), progress typedef, and the function that unpacks element i of the pattern.
- Sub-module seq_fallback (purely combinational): inputs pattern, p, x and mode_overlap; outputs next progress and match.
- The top level holds the registers: pattern, progress, alarm and counter.

Test Plan:
- Reset, then stream 1,2,3 with sym_valid=1 -> match_pulse=1 and alarm=1 in the cycle after 3; match_count=1; progress=0.
- Stream 1,2,1,2,3 (restart mode) -> progress runs 1,2,1,2,0 with exactly one match after the final 3. The same stream with gaps of sym_valid=0 between symbols gives the same result.
- cfg_load with pattern 1,1,1:
  - Stream 1,1,1,1,1 in overlap mode -> 3 matches, progress after each match=2.
  - Same stream in restart mode -> 1 match.
- mode_latch=1: match, then 5 idle cycles -> alarm held high. alarm_clr with a simultaneous match -> alarm stays 1. alarm_clr alone -> alarm=0 on the next cycle.
- CNT_W=2: 5 matches -> match_count stops at 3.
- Reset asserted after 1,2 together with sym=3 valid -> no match; progress=0. After reset, stream 3 -> no match.
